// File: rtl/pwm_dec_pkg.sv
// Shared types and helpers for the PWM sample decoder.
package pwm_dec_pkg;

  // Decoder state machine encoding.
  typedef enum logic [1:0] {
    ST_WAIT_EDGE = 2'd0,
    ST_MEASURE   = 2'd1,
    ST_STUCK     = 2'd2
  } pwm_state_e;

  // Default stuck timeout: two nominal PWM periods of 2^w cycles.
  function automatic int default_timeout(input int w);
    return 2 ** (w + 1);
  endfunction

  // Clamp a value to the largest unsigned number representable in w bits.
  function automatic logic [31:0] sat_to_width(input logic [31:0] val, input int w);
    logic [31:0] max_v;
    max_v = (32'd1 << w) - 32'd1;
    if (val > max_v) begin
      return max_v;
    end else begin
      return val;
    end
  endfunction

endpackage

// File: rtl/pwm_in_sync.sv
// Input conditioning for the PWM decoder: 2-flop synchronizer, optional
// 3-sample majority glitch filter (enabled by PWM_DEC_GLITCH_FILTER_EN),
// and rising-edge detection. `rise` is combinational so that the decoder's
// output register is the only stage after the synchronizer/filter.
module pwm_in_sync (
  input  logic clk1,
  input  logic reset,
  input  logic pwm_in,
  output logic pwm_s,
  output logic rise
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;
  logic filt_s;

  // Two-stage synchronizer for the asynchronous PWM pin.
  always_ff @(posedge clk1) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= pwm_in;
      sync2_q <= sync1_q;
    end
  end

`ifdef PWM_DEC_GLITCH_FILTER_EN
  logic [2:0] hist_q;

  // Majority of three samples; a single odd sample never wins.
  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

  // Three-sample history of the synchronized input for the majority vote.
  always_ff @(posedge clk1) begin
    if (reset) begin
      hist_q <= 3'b000;
    end else begin
      hist_q <= {hist_q[1:0], sync2_q};
    end
  end

  assign filt_s = maj3(hist_q);
`else
  assign filt_s = sync2_q;
`endif

  // Previous conditioned level, used for rising-edge detection.
  always_ff @(posedge clk1) begin
    if (reset) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= filt_s;
    end
  end

  assign pwm_s = filt_s;
  assign rise  = filt_s & ~prev_q;

endmodule

// File: rtl/pwm_sample_decoder.sv
// PWM sample decoder: measures the high time of each PWM period and emits
// it as a `width`-bit sample over a single-entry valid/ready buffer.
// A missing rising edge for TIMEOUT cycles enters STUCK, which re-emits the
// rail value (0 or full scale) every TIMEOUT cycles until edges return.
// Optional feature macro: PWM_DEC_GLITCH_FILTER_EN (majority glitch filter
// in pwm_in_sync; adds 2 cycles of latency).
module pwm_sample_decoder
  import pwm_dec_pkg::*;
#(
  parameter int width   = 12,
  parameter int TIMEOUT = default_timeout(width)
) (
  input  logic             clk1,
  input  logic             reset,
  input  logic             pwm_in,
  output logic [width-1:0] sample_out,
  output logic             sample_valid,
  input  logic             sample_ready,
  output logic             overrun,
  output logic             stuck
);

  localparam int PW = width + 2;
  localparam int HW = width + 1;
  localparam logic [PW-1:0]    P_ONE     = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [PW-1:0]    P_TIMEOUT = PW'(TIMEOUT);
  localparam logic [HW-1:0]    H_ONE     = {{(HW-1){1'b0}}, 1'b1};
  localparam logic [HW-1:0]    H_MAX     = {HW{1'b1}};
  localparam logic [width-1:0] S_MAX     = {width{1'b1}};
  localparam logic [width-1:0] S_ZERO    = {width{1'b0}};

  logic pwm_s;
  logic rise;

  pwm_in_sync u_sync (
    .clk1   (clk1),
    .reset  (reset),
    .pwm_in (pwm_in),
    .pwm_s  (pwm_s),
    .rise   (rise)
  );

  pwm_state_e       state_q, state_d;
  logic [PW-1:0]    period_cnt_q, period_cnt_d;
  logic [HW-1:0]    high_cnt_q, high_cnt_d;
  logic [width-1:0] sample_q, sample_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;
  logic             stuck_q, stuck_d;

  logic             timeout_s;
  logic             emit_s;
  logic [width-1:0] emit_val_s;
  logic [width-1:0] rail_val_s;
  logic [31:0]      sat_s;

  assign timeout_s  = (period_cnt_q == P_TIMEOUT);
  assign sat_s      = sat_to_width(32'(high_cnt_q), width);
  assign rail_val_s = pwm_s ? S_MAX : S_ZERO;

  // State register.
  always_ff @(posedge clk1) begin
    if (reset) begin
      state_q <= ST_WAIT_EDGE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and emit decision; a rising edge beats a timeout.
  always_comb begin
    state_d    = state_q;
    emit_s     = 1'b0;
    emit_val_s = S_ZERO;
    case (state_q)
      ST_WAIT_EDGE: begin
        if (rise) begin
          state_d = ST_MEASURE;
        end else if (timeout_s) begin
          state_d    = ST_STUCK;
          emit_s     = 1'b1;
          emit_val_s = rail_val_s;
        end else begin
          state_d = ST_WAIT_EDGE;
        end
      end
      ST_MEASURE: begin
        if (rise) begin
          emit_s     = 1'b1;
          emit_val_s = width'(sat_s);
        end else if (timeout_s) begin
          state_d    = ST_STUCK;
          emit_s     = 1'b1;
          emit_val_s = rail_val_s;
        end else begin
          state_d = ST_MEASURE;
        end
      end
      ST_STUCK: begin
        if (rise) begin
          state_d = ST_MEASURE;
        end else if (timeout_s) begin
          emit_s     = 1'b1;
          emit_val_s = rail_val_s;
        end else begin
          state_d = ST_STUCK;
        end
      end
      default: begin
        state_d = ST_WAIT_EDGE;
      end
    endcase
  end

  // Counter next values. The period counter also restarts on timeout so
  // STUCK re-emits every TIMEOUT cycles.
  always_comb begin
    period_cnt_d = period_cnt_q + P_ONE;
    high_cnt_d   = high_cnt_q;
    if (rise || timeout_s) begin
      period_cnt_d = P_ONE;
    end else begin
      period_cnt_d = period_cnt_q + P_ONE;
    end
    if (rise) begin
      high_cnt_d = H_ONE;
    end else if (pwm_s && (high_cnt_q != H_MAX)) begin
      high_cnt_d = high_cnt_q + H_ONE;
    end else begin
      high_cnt_d = high_cnt_q;
    end
  end

  // Period and high-time counters.
  always_ff @(posedge clk1) begin
    if (reset) begin
      period_cnt_q <= {PW{1'b0}};
      high_cnt_q   <= {HW{1'b0}};
    end else begin
      period_cnt_q <= period_cnt_d;
      high_cnt_q   <= high_cnt_d;
    end
  end

  // Single-entry output buffer with overwrite-on-overrun.
  always_comb begin
    sample_d  = sample_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;
    stuck_d   = (state_d == ST_STUCK);
    if (emit_s) begin
      sample_d  = emit_val_s;
      valid_d   = 1'b1;
      overrun_d = valid_q & ~sample_ready;
    end else if (valid_q && sample_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk1) begin
    if (reset) begin
      sample_q  <= S_ZERO;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      stuck_q   <= 1'b0;
    end else begin
      sample_q  <= sample_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      stuck_q   <= stuck_d;
    end
  end

  assign sample_out   = sample_q;
  assign sample_valid = valid_q;
  assign overrun      = overrun_q;
  assign stuck        = stuck_q;

endmodule

// File: tb/tb_pwm_sample_decoder.sv
// Directed testbench for pwm_sample_decoder with width=4, TIMEOUT=32.
module tb_pwm_sample_decoder;

  localparam int W = 4;
`ifdef PWM_DEC_GLITCH_FILTER_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 3;
`endif

  logic         clk1         = 1'b0;
  logic         reset        = 1'b1;
  logic         pwm_in       = 1'b0;
  logic         sample_ready = 1'b1;
  logic [W-1:0] sample_out;
  logic         sample_valid;
  logic         overrun;
  logic         stuck;

  int n_cmp   = 0;
  int n_err   = 0;
  int cyc_cnt = 0;
  int ovr_cnt = 0;
  int ovr_cyc = -1;
  int log_val[$];
  int log_cyc[$];
  logic valid_prev = 1'b0;

  pwm_sample_decoder #(.width(W), .TIMEOUT(32)) dut (
    .clk1         (clk1),
    .reset        (reset),
    .pwm_in       (pwm_in),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .overrun      (overrun),
    .stuck        (stuck)
  );

  always #5 clk1 = ~clk1;

  // Monitor: logs every load of the output buffer (valid rising or overwrite).
  initial begin
    forever begin
      @(posedge clk1);
      cyc_cnt++;
      #1;
      if (sample_valid === 1'b1 && (valid_prev !== 1'b1 || overrun === 1'b1)) begin
        log_val.push_back(int'(sample_out));
        log_cyc.push_back(cyc_cnt);
      end
      if (overrun === 1'b1) begin
        ovr_cnt++;
        ovr_cyc = cyc_cnt;
      end
      valid_prev = sample_valid;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk1);
      #1;
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    pwm_in = 1'b0;
    sample_ready = 1'b1;
    step(2);
    reset = 1'b0;
    log_val.delete();
    log_cyc.delete();
    ovr_cnt = 0;
    ovr_cyc = -1;
  endtask

  task automatic run_pwm(input int high, input int per, input int n);
    for (int p = 0; p < n; p++) begin
      for (int i = 0; i < per; i++) begin
        pwm_in = (i < high);
        step(1);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(2);
    n_cmp++; if (sample_out !== 4'd0) begin n_err++; $display("FAIL reset_sample_out: got %0d want 0", sample_out); end
    n_cmp++; if (sample_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", sample_valid); end
    n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    n_cmp++; if (stuck !== 1'b0) begin n_err++; $display("FAIL reset_stuck: got %b want 0", stuck); end
  endtask

  task automatic test_basic();
    int c0;
    int e_v[$];
    int e_c[$];
    apply_reset();
    c0 = cyc_cnt;
    run_pwm(5, 16, 4);
    pwm_in = 1'b0;
    step(4);
    e_v = '{5, 5, 5};
    e_c = '{c0 + 16 + LAT, c0 + 32 + LAT, c0 + 48 + LAT};
    n_cmp++; if (log_val.size() !== e_v.size()) begin n_err++; $display("FAIL basic_count: got %0d want %0d", log_val.size(), e_v.size()); end
    for (int i = 0; i < e_v.size(); i++) begin
      n_cmp++;
      if (i >= log_val.size()) begin n_err++; $display("FAIL basic_s%0d: missing, want %0d @%0d", i, e_v[i], e_c[i]); end
      else if (log_val[i] !== e_v[i] || log_cyc[i] !== e_c[i]) begin n_err++; $display("FAIL basic_s%0d: got %0d @%0d want %0d @%0d", i, log_val[i], log_cyc[i], e_v[i], e_c[i]); end
    end
  endtask

  task automatic test_stuck_high();
    int c0;
    int c1;
    int e_v[$];
    int e_c[$];
    apply_reset();
    c0 = cyc_cnt;
    pwm_in = 1'b1;
    step(70);
    n_cmp++; if (stuck !== 1'b1) begin n_err++; $display("FAIL stuckhi_flag: got %b want 1", stuck); end
    pwm_in = 1'b0;
    step(9);
    c1 = cyc_cnt;
    run_pwm(7, 16, 2);
    pwm_in = 1'b0;
    step(2);
    n_cmp++; if (stuck !== 1'b0) begin n_err++; $display("FAIL stuckhi_exit: got %b want 0", stuck); end
    e_v = '{15, 15, 7};
    e_c = '{c0 + LAT + 32, c0 + LAT + 64, c1 + 16 + LAT};
    n_cmp++; if (log_val.size() !== e_v.size()) begin n_err++; $display("FAIL stuckhi_count: got %0d want %0d", log_val.size(), e_v.size()); end
    for (int i = 0; i < e_v.size(); i++) begin
      n_cmp++;
      if (i >= log_val.size()) begin n_err++; $display("FAIL stuckhi_s%0d: missing, want %0d @%0d", i, e_v[i], e_c[i]); end
      else if (log_val[i] !== e_v[i] || log_cyc[i] !== e_c[i]) begin n_err++; $display("FAIL stuckhi_s%0d: got %0d @%0d want %0d @%0d", i, log_val[i], log_cyc[i], e_v[i], e_c[i]); end
    end
  endtask

  task automatic test_stuck_low();
    int c0;
    apply_reset();
    c0 = cyc_cnt;
    run_pwm(3, 16, 1);
    pwm_in = 1'b0;
    step(LAT + 31 - 16);
    n_cmp++; if (stuck !== 1'b0) begin n_err++; $display("FAIL stucklo_early: got %b want 0", stuck); end
    step(1);
    n_cmp++; if (stuck !== 1'b1) begin n_err++; $display("FAIL stucklo_flag: got %b want 1", stuck); end
    n_cmp++; if (sample_valid !== 1'b1 || sample_out !== 4'd0) begin n_err++; $display("FAIL stucklo_sample: got valid=%b out=%0d want valid=1 out=0", sample_valid, sample_out); end
    step(2);
    n_cmp++;
    if (log_val.size() !== 1) begin n_err++; $display("FAIL stucklo_count: got %0d want 1", log_val.size()); end
    else if (log_val[0] !== 0 || log_cyc[0] !== c0 + LAT + 32) begin n_err++; $display("FAIL stucklo_s0: got %0d @%0d want 0 @%0d", log_val[0], log_cyc[0], c0 + LAT + 32); end
  endtask

  task automatic test_overrun();
    int c0;
    int e_v[$];
    int e_c[$];
    apply_reset();
    sample_ready = 1'b0;
    c0 = cyc_cnt;
    run_pwm(4, 16, 1);
    run_pwm(9, 16, 1);
    run_pwm(3, 16, 1);
    pwm_in = 1'b0;
    n_cmp++; if (sample_out !== 4'd9 || sample_valid !== 1'b1) begin n_err++; $display("FAIL ovr_hold: got out=%0d valid=%b want out=9 valid=1", sample_out, sample_valid); end
    n_cmp++; if (ovr_cnt !== 1 || ovr_cyc !== c0 + 32 + LAT) begin n_err++; $display("FAIL ovr_pulse: got %0d pulses @%0d want 1 @%0d", ovr_cnt, ovr_cyc, c0 + 32 + LAT); end
    sample_ready = 1'b1;
    step(1);
    n_cmp++; if (sample_valid !== 1'b0) begin n_err++; $display("FAIL ovr_drain: got valid=%b want 0", sample_valid); end
    e_v = '{4, 9};
    e_c = '{c0 + 16 + LAT, c0 + 32 + LAT};
    n_cmp++; if (log_val.size() !== e_v.size()) begin n_err++; $display("FAIL ovr_count: got %0d want %0d", log_val.size(), e_v.size()); end
    for (int i = 0; i < e_v.size(); i++) begin
      n_cmp++;
      if (i >= log_val.size()) begin n_err++; $display("FAIL ovr_s%0d: missing, want %0d @%0d", i, e_v[i], e_c[i]); end
      else if (log_val[i] !== e_v[i] || log_cyc[i] !== e_c[i]) begin n_err++; $display("FAIL ovr_s%0d: got %0d @%0d want %0d @%0d", i, log_val[i], log_cyc[i], e_v[i], e_c[i]); end
    end
  endtask

  task automatic test_reset_mid();
    int c1;
    int e_v[$];
    int e_c[$];
    apply_reset();
    run_pwm(6, 16, 2);
    run_pwm(6, 8, 1);
    reset = 1'b1;
    step(1);
    n_cmp++; if (sample_out !== 4'd0 || sample_valid !== 1'b0 || overrun !== 1'b0 || stuck !== 1'b0) begin n_err++; $display("FAIL midrst_outputs: got out=%0d valid=%b ovr=%b stuck=%b want all 0", sample_out, sample_valid, overrun, stuck); end
    reset = 1'b0;
    log_val.delete();
    log_cyc.delete();
    c1 = cyc_cnt;
    run_pwm(5, 16, 3);
    pwm_in = 1'b0;
    step(4);
    e_v = '{5, 5};
    e_c = '{c1 + 16 + LAT, c1 + 32 + LAT};
    n_cmp++; if (log_val.size() !== e_v.size()) begin n_err++; $display("FAIL midrst_count: got %0d want %0d", log_val.size(), e_v.size()); end
    for (int i = 0; i < e_v.size(); i++) begin
      n_cmp++;
      if (i >= log_val.size()) begin n_err++; $display("FAIL midrst_s%0d: missing, want %0d @%0d", i, e_v[i], e_c[i]); end
      else if (log_val[i] !== e_v[i] || log_cyc[i] !== e_c[i]) begin n_err++; $display("FAIL midrst_s%0d: got %0d @%0d want %0d @%0d", i, log_val[i], log_cyc[i], e_v[i], e_c[i]); end
    end
  endtask

  task automatic test_glitch();
    int c0;
    int e_v[$];
    int e_c[$];
    apply_reset();
    c0 = cyc_cnt;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 16; i++) begin
        pwm_in = (i < 10) && (i != 5);
        step(1);
      end
    end
    run_pwm(8, 16, 1);
    pwm_in = 1'b0;
    step(3);
`ifdef PWM_DEC_GLITCH_FILTER_EN
    e_v = '{10, 10};
    e_c = '{c0 + 16 + LAT, c0 + 32 + LAT};
`else
    e_v = '{5, 4, 5, 4};
    e_c = '{c0 + 6 + LAT, c0 + 16 + LAT, c0 + 22 + LAT, c0 + 32 + LAT};
`endif
    n_cmp++; if (log_val.size() !== e_v.size()) begin n_err++; $display("FAIL glitch_count: got %0d want %0d", log_val.size(), e_v.size()); end
    for (int i = 0; i < e_v.size(); i++) begin
      n_cmp++;
      if (i >= log_val.size()) begin n_err++; $display("FAIL glitch_s%0d: missing, want %0d @%0d", i, e_v[i], e_c[i]); end
      else if (log_val[i] !== e_v[i] || log_cyc[i] !== e_c[i]) begin n_err++; $display("FAIL glitch_s%0d: got %0d @%0d want %0d @%0d", i, log_val[i], log_cyc[i], e_v[i], e_c[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stuck_high();
    test_stuck_low();
    test_overrun();
    test_reset_mid();
    test_glitch();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
